// File: rtl/spibone_burst_bridge.sv
// spibone_burst_bridge
//   SPI-slave (mode 0, MSB first) to Wishbone-master bridge with multi-word
//   incrementing bursts buffered through an internal word FIFO. Everything
//   runs on clk48; the SPI pins are brought in through 2-FF synchronisers.
//
//   Frame: OP (0x01 write / 0x02 read), LEN (words-1), A3..A0 (byte address,
//   big-endian), then payload. Writes stream words into the FIFO while the
//   bus side drains it, followed by status bytes (0xFF busy, 0x00 ok,
//   0xEE error). Reads return 0xFF until the burst is buffered, one sync
//   byte (0x00 / 0xEE), then the words big-endian (ok case only), then 0xFF.
//
//   Optional feature macro: SPIBONE_WB_TIMEOUT_EN -- bus watchdog that turns
//   a strobe left unanswered for TIMEOUT_CYCLES cycles into an error.
//
// Ports
//   clk48, reset_n                 clock, asynchronous active-low reset
//   spi_clk, spi_cs_n, spi_mosi    SPI inputs (asynchronous to clk48)
//   spi_miso                       SPI data out
//   wishbone_*                     Wishbone master (cyc/stb/we/adr/dat/sel/cti/bte,
//                                  ack/err terminations)
module spibone_burst_bridge #(
    parameter int DATA_W         = 32,
    parameter int ADDR_W         = 30,
    parameter int FIFO_DEPTH     = 16,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic                clk48,
    input  logic                reset_n,
    input  logic                spi_clk,
    input  logic                spi_cs_n,
    input  logic                spi_mosi,
    output logic                spi_miso,
    output logic [ADDR_W-1:0]   wishbone_adr,
    output logic [DATA_W-1:0]   wishbone_dat_w,
    input  logic [DATA_W-1:0]   wishbone_dat_r,
    output logic [DATA_W/8-1:0] wishbone_sel,
    output logic                wishbone_cyc,
    output logic                wishbone_stb,
    output logic                wishbone_we,
    output logic [2:0]          wishbone_cti,
    output logic [1:0]          wishbone_bte,
    input  logic                wishbone_ack,
    input  logic                wishbone_err
);
    localparam int         BPW    = DATA_W / 8;
    localparam int         AW     = $clog2(FIFO_DEPTH);
    localparam logic [1:0] LAST_B = 2'(BPW - 1);
    localparam logic [8:0] DEPTH9 = 9'(FIFO_DEPTH);
    localparam logic [2:0] CTI_INC = 3'b010;
    localparam logic [2:0] CTI_END = 3'b111;

    typedef enum logic [2:0] {S_IDLE, S_OP, S_LEN, S_ADDR, S_WDATA, S_STATUS, S_RWAIT, S_RDATA} spi_st_t;
    typedef enum logic [1:0] {B_IDLE, B_REQ, B_DONE} bus_st_t;

    // ---- synchronisers and edge detect ----
    logic [2:0] sclk_q, cs_q;
    logic [1:0] mosi_q;
    always_ff @(posedge clk48 or negedge reset_n) begin
        if (!reset_n) begin
            sclk_q <= 3'b000;
            cs_q   <= 3'b111;
            mosi_q <= 2'b00;
        end else begin
            sclk_q <= {sclk_q[1:0], spi_clk};
            cs_q   <= {cs_q[1:0], spi_cs_n};
            mosi_q <= {mosi_q[0], spi_mosi};
        end
    end

    logic cs_high, cs_rise, cs_fall, sclk_rise, sclk_fall, mosi_s;
    assign cs_high   = cs_q[1];
    assign cs_rise   = cs_q[1] & ~cs_q[2];
    assign cs_fall   = ~cs_q[1] & cs_q[2];
    assign sclk_rise = sclk_q[1] & ~sclk_q[2] & ~cs_q[1];
    assign sclk_fall = ~sclk_q[1] & sclk_q[2] & ~cs_q[1];
    assign mosi_s    = mosi_q[1];

    // ---- state and shared signals ----
    spi_st_t             spi_st_q;
    bus_st_t             bus_st_q;
    logic [2:0]          bit_cnt_q;
    logic [1:0]          bidx_q;
    logic [8:0]          left_q, bleft_q;
    logic                is_wr_q, berr_q;
    logic [6:0]          rx_q;
    logic [23:0]         addr_q;
    logic [DATA_W-1:0]   wsh_q, rsh_q;
    logic [7:0]          tx_q, next_tx;
    logic                miso_q;
    logic                cyc_q, stb_q, we_q;
    logic [ADDR_W-1:0]   adr_q;
    logic [DATA_W-1:0]   dat_w_q;
    logic [BPW-1:0]      sel_q;
    logic [2:0]          cti_q;
    logic                timeout;

    logic [7:0]        rx_byte;
    logic [31:0]       addr_cat;
    logic [DATA_W-1:0] wr_word, fifo_head;
    logic [8:0]        len_p1, n_clamp;
    logic              byte_done, boundary, spi_push, spi_pop, bus_start, rd_byte_now;
    logic              bus_done, bus_push, bus_pop, flush, fifo_empty;

    assign rx_byte     = {rx_q, mosi_s};
    assign addr_cat    = {addr_q, rx_byte};
    assign wr_word     = (wsh_q << 8) | DATA_W'(rx_byte);
    assign byte_done   = sclk_rise && (bit_cnt_q == 3'd7);
    assign boundary    = sclk_fall && (bit_cnt_q == 3'd0);
    assign spi_push    = byte_done && (spi_st_q == S_WDATA) && (bidx_q == LAST_B);
    assign bus_start   = byte_done && (spi_st_q == S_ADDR) && (bidx_q == 2'd3);
    assign rd_byte_now = boundary && (spi_st_q == S_RDATA) && (left_q != 9'd0);
    assign spi_pop     = rd_byte_now && (bidx_q == 2'd0);
    assign len_p1      = {1'b0, rx_byte} + 9'd1;
    assign n_clamp     = (len_p1 > DEPTH9) ? DEPTH9 : len_p1;
    assign bus_done    = (bus_st_q == B_DONE);

    // The two address byte-offset bits are not part of the word address.
    logic unused_bits;
    assign unused_bits = ^addr_cat[1:0];

    // Byte to shift out starting at the next byte boundary.
    always_comb begin
        next_tx = 8'hFF;
        case (spi_st_q)
            S_STATUS, S_RWAIT: if (bus_done) next_tx = berr_q ? 8'hEE : 8'h00;
            S_RDATA: if (left_q != 9'd0)
                next_tx = (bidx_q == 2'd0) ? fifo_head[DATA_W-1 -: 8] : rsh_q[DATA_W-1 -: 8];
            default: ;
        endcase
    end

    // ---- word FIFO ----
    logic [DATA_W-1:0] mem [FIFO_DEPTH];
    logic [AW:0]       wptr_q, rptr_q;
    logic              push, pop;
    assign push       = spi_push | bus_push;
    assign pop        = spi_pop | bus_pop;
    assign fifo_empty = (wptr_q == rptr_q);
    assign fifo_head  = mem[rptr_q[AW-1:0]];

    always_ff @(posedge clk48 or negedge reset_n) begin
        if (!reset_n) begin
            wptr_q <= '0;
            rptr_q <= '0;
        end else if (flush) begin
            wptr_q <= '0;
            rptr_q <= '0;
        end else begin
            if (push) wptr_q <= wptr_q + (AW+1)'(1);
            if (pop)  rptr_q <= rptr_q + (AW+1)'(1);
        end
    end

    always_ff @(posedge clk48) begin
        if (push) mem[wptr_q[AW-1:0]] <= spi_push ? wr_word : wishbone_dat_r;
    end

    // ---- SPI datapath shifters (no reset needed) ----
    always_ff @(posedge clk48) begin
        if (sclk_rise) rx_q <= rx_byte[6:0];
        if (byte_done && spi_st_q == S_ADDR)  addr_q <= addr_cat[23:0];
        if (byte_done && spi_st_q == S_WDATA) wsh_q  <= wr_word;
        if (rd_byte_now) rsh_q <= ((bidx_q == 2'd0) ? fifo_head : rsh_q) << 8;
    end

    // ---- SPI frame FSM ----
    always_ff @(posedge clk48 or negedge reset_n) begin
        if (!reset_n) begin
            spi_st_q  <= S_IDLE;
            bit_cnt_q <= 3'd0;
            bidx_q    <= 2'd0;
            left_q    <= 9'd0;
            is_wr_q   <= 1'b0;
            tx_q      <= 8'hFF;
            miso_q    <= 1'b1;
        end else if (cs_rise) begin
            spi_st_q <= S_IDLE;
            miso_q   <= 1'b1;
        end else if (cs_fall) begin
            spi_st_q  <= S_OP;
            bit_cnt_q <= 3'd0;
            bidx_q    <= 2'd0;
            tx_q      <= 8'hFF;
            miso_q    <= 1'b1;
        end else begin
            if (sclk_rise) begin
                bit_cnt_q <= bit_cnt_q + 3'd1;
                if (bit_cnt_q == 3'd7) begin
                    case (spi_st_q)
                        S_OP: begin
                            if (rx_byte == 8'h01 || rx_byte == 8'h02) begin
                                is_wr_q  <= (rx_byte == 8'h01);
                                spi_st_q <= S_LEN;
                            end else begin
                                // Unknown opcode: RDATA with nothing left sends 0xFF forever.
                                spi_st_q <= S_RDATA;
                                left_q   <= 9'd0;
                            end
                        end
                        S_LEN: begin
                            left_q   <= n_clamp;
                            bidx_q   <= 2'd0;
                            spi_st_q <= S_ADDR;
                        end
                        S_ADDR: begin
                            if (bidx_q == 2'd3) begin
                                bidx_q   <= 2'd0;
                                spi_st_q <= is_wr_q ? S_WDATA : S_RWAIT;
                            end else begin
                                bidx_q <= bidx_q + 2'd1;
                            end
                        end
                        S_WDATA: begin
                            if (bidx_q == LAST_B) begin
                                bidx_q <= 2'd0;
                                left_q <= left_q - 9'd1;
                                if (left_q == 9'd1) spi_st_q <= S_STATUS;
                            end else begin
                                bidx_q <= bidx_q + 2'd1;
                            end
                        end
                        default: ;
                    endcase
                end
            end
            if (sclk_fall) begin
                if (bit_cnt_q == 3'd0) begin
                    tx_q   <= next_tx;
                    miso_q <= next_tx[7];
                    // Sync byte goes out now; on error no data follows.
                    if (spi_st_q == S_RWAIT && bus_done) begin
                        spi_st_q <= S_RDATA;
                        if (berr_q) left_q <= 9'd0;
                    end
                    if (rd_byte_now) begin
                        if (bidx_q == LAST_B) begin
                            bidx_q <= 2'd0;
                            left_q <= left_q - 9'd1;
                        end else begin
                            bidx_q <= bidx_q + 2'd1;
                        end
                    end
                end else begin
                    miso_q <= tx_q[3'd7 - bit_cnt_q];
                end
            end
        end
    end

    // ---- bus watchdog ----
`ifdef SPIBONE_WB_TIMEOUT_EN
    localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [TO_W-1:0] to_cnt_q;
    always_ff @(posedge clk48 or negedge reset_n) begin
        if (!reset_n)     to_cnt_q <= '0;
        else if (!stb_q)  to_cnt_q <= '0;
        else              to_cnt_q <= to_cnt_q + TO_W'(1);
    end
    assign timeout = stb_q && (to_cnt_q == TO_W'(TIMEOUT_CYCLES - 1));
`else
    localparam int unused_timeout = TIMEOUT_CYCLES;
    assign timeout = 1'b0;
`endif

    // ---- Wishbone burst FSM ----
    logic bus_fail;
    assign bus_fail = (bus_st_q == B_REQ) && stb_q && (wishbone_err || timeout);
    assign bus_push = (bus_st_q == B_REQ) && stb_q && !we_q && wishbone_ack && !bus_fail;
    assign bus_pop  = (bus_st_q == B_REQ) && !stb_q && !cs_high && we_q && !fifo_empty;
    assign flush    = bus_fail || (bus_done && spi_st_q == S_IDLE);

    always_ff @(posedge clk48 or negedge reset_n) begin
        if (!reset_n) begin
            bus_st_q <= B_IDLE;
            cyc_q    <= 1'b0;
            stb_q    <= 1'b0;
            we_q     <= 1'b0;
            adr_q    <= '0;
            dat_w_q  <= '0;
            sel_q    <= '0;
            cti_q    <= 3'b000;
            bleft_q  <= 9'd0;
            berr_q   <= 1'b0;
        end else begin
            case (bus_st_q)
                B_IDLE: if (bus_start) begin
                    bus_st_q <= B_REQ;
                    cyc_q    <= 1'b1;
                    we_q     <= is_wr_q;
                    adr_q    <= addr_cat[ADDR_W+1:2];
                    bleft_q  <= left_q;
                    berr_q   <= 1'b0;
                    if (!is_wr_q) begin
                        stb_q <= 1'b1;
                        sel_q <= '1;
                        cti_q <= (left_q == 9'd1) ? CTI_END : CTI_INC;
                    end
                end
                B_REQ: begin
                    if (stb_q) begin
                        if (bus_fail) begin
                            stb_q    <= 1'b0;
                            sel_q    <= '0;
                            cyc_q    <= 1'b0;
                            berr_q   <= 1'b1;
                            bus_st_q <= B_DONE;
                        end else if (wishbone_ack) begin
                            stb_q   <= 1'b0;
                            sel_q   <= '0;
                            adr_q   <= adr_q + ADDR_W'(1);
                            bleft_q <= bleft_q - 9'd1;
                            if (bleft_q == 9'd1 || cs_high) begin
                                cyc_q    <= 1'b0;
                                bus_st_q <= B_DONE;
                            end
                        end
                    end else if (cs_high) begin
                        // Host abandoned the frame between words.
                        cyc_q    <= 1'b0;
                        bus_st_q <= B_DONE;
                    end else if (!we_q || !fifo_empty) begin
                        stb_q <= 1'b1;
                        sel_q <= '1;
                        cti_q <= (bleft_q == 9'd1) ? CTI_END : CTI_INC;
                        if (we_q) dat_w_q <= fifo_head;
                    end
                end
                default: if (spi_st_q == S_IDLE) bus_st_q <= B_IDLE;
            endcase
        end
    end

    assign spi_miso       = miso_q;
    assign wishbone_adr   = adr_q;
    assign wishbone_dat_w = dat_w_q;
    assign wishbone_sel   = sel_q;
    assign wishbone_cyc   = cyc_q;
    assign wishbone_stb   = stb_q;
    assign wishbone_we    = we_q;
    assign wishbone_cti   = cti_q;
    assign wishbone_bte   = 2'b00;
endmodule

// File: tb/tb_spibone_burst_bridge.sv
// Directed testbench for spibone_burst_bridge: drives SPI frames as a mode-0
// host and models a Wishbone slave that logs every terminated bus word.
module tb_spibone_burst_bridge;
    localparam int DATA_W = 32;
    localparam int ADDR_W = 30;

    logic              clk48 = 1'b0;
    logic              reset_n = 1'b1;
    logic              spi_clk = 1'b0, spi_cs_n = 1'b1, spi_mosi = 1'b0;
    logic              spi_miso;
    logic [ADDR_W-1:0] wishbone_adr;
    logic [DATA_W-1:0] wishbone_dat_w;
    logic [DATA_W-1:0] wishbone_dat_r = '0;
    logic [3:0]        wishbone_sel;
    logic              wishbone_cyc, wishbone_stb, wishbone_we;
    logic [2:0]        wishbone_cti;
    logic [1:0]        wishbone_bte;
    logic              wishbone_ack = 1'b0, wishbone_err = 1'b0;

    always #5 clk48 = ~clk48;

    spibone_burst_bridge #(
        .DATA_W(DATA_W), .ADDR_W(ADDR_W), .FIFO_DEPTH(16), .TIMEOUT_CYCLES(64)
    ) dut (
        .clk48(clk48), .reset_n(reset_n),
        .spi_clk(spi_clk), .spi_cs_n(spi_cs_n), .spi_mosi(spi_mosi), .spi_miso(spi_miso),
        .wishbone_adr(wishbone_adr), .wishbone_dat_w(wishbone_dat_w), .wishbone_dat_r(wishbone_dat_r),
        .wishbone_sel(wishbone_sel), .wishbone_cyc(wishbone_cyc), .wishbone_stb(wishbone_stb),
        .wishbone_we(wishbone_we), .wishbone_cti(wishbone_cti), .wishbone_bte(wishbone_bte),
        .wishbone_ack(wishbone_ack), .wishbone_err(wishbone_err)
    );

    // ---- Wishbone slave model and bus log ----
    int   err_at = -1;
    bit   noack = 1'b0;
    int   widx = 0, log_n = 0, stb_rises = 0, stb_hi = 0;
    logic stb_prev = 1'b0;
    logic [31:0] log_adr [64];
    logic [31:0] log_dat [64];
    logic [2:0]  log_cti [64];
    logic        log_we  [64];
    logic [3:0]  log_sel [64];

    always @(posedge clk48) begin
        stb_prev <= wishbone_stb;
        if (wishbone_stb && !stb_prev) stb_rises <= stb_rises + 1;
        if (wishbone_cyc && wishbone_stb) stb_hi <= stb_hi + 1;
        wishbone_ack <= 1'b0;
        wishbone_err <= 1'b0;
        if (!wishbone_cyc) begin
            widx <= 0;
        end else if (wishbone_stb && !wishbone_ack && !wishbone_err && !noack) begin
            log_adr[log_n % 64] <= 32'(wishbone_adr);
            log_dat[log_n % 64] <= wishbone_dat_w;
            log_cti[log_n % 64] <= wishbone_cti;
            log_we[log_n % 64]  <= wishbone_we;
            log_sel[log_n % 64] <= wishbone_sel;
            log_n <= log_n + 1;
            widx  <= widx + 1;
            if (widx == err_at) wishbone_err <= 1'b1;
            else begin
                wishbone_ack   <= 1'b1;
                wishbone_dat_r <= 32'(32'h11111111 * (widx + 1));
            end
        end
    end

    // ---- checking ----
    int n_chk = 0, n_fail = 0;
    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // ---- SPI host ----
    task automatic spi_byte(input logic [7:0] tx, output logic [7:0] rx);
        for (int i = 7; i >= 0; i--) begin
            spi_mosi = tx[i];
            #50 spi_clk = 1'b1;
            rx[i] = spi_miso;
            #50 spi_clk = 1'b0;
        end
    endtask

    task automatic cs_assert();
        spi_cs_n = 1'b0;
        #100;
    endtask

    task automatic cs_release();
        #100 spi_cs_n = 1'b1;
        #200;
    endtask

    task automatic send_hdr(input logic [7:0] op, input logic [7:0] len, input logic [31:0] a);
        logic [7:0] d;
        spi_byte(op, d);
        spi_byte(len, d);
        for (int i = 3; i >= 0; i--) spi_byte(a[i*8 +: 8], d);
    endtask

    task automatic send_word(input logic [31:0] w);
        logic [7:0] d;
        for (int i = 3; i >= 0; i--) spi_byte(w[i*8 +: 8], d);
    endtask

    task automatic recv_word(output logic [31:0] w);
        logic [7:0] d;
        for (int i = 3; i >= 0; i--) begin
            spi_byte(8'h00, d);
            w[i*8 +: 8] = d;
        end
    endtask

    // Clocks dummy bytes until something other than 0xFF comes back (bounded).
    task automatic wait_nonff(input int maxb, output logic [7:0] r);
        r = 8'hFF;
        for (int i = 0; i < maxb && r == 8'hFF; i++) spi_byte(8'h00, r);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
        $fatal(1);
    end

    initial begin
        logic [7:0]  b;
        logic [31:0] w;
        int base, r0, h0;

        // Reset
        #2 reset_n = 1'b0;
        repeat (4) @(posedge clk48);
        #1;
        chk("rst_miso", 32'(spi_miso), 1);
        chk("rst_cyc", 32'(wishbone_cyc), 0);
        chk("rst_stb", 32'(wishbone_stb), 0);
        chk("rst_we", 32'(wishbone_we), 0);
        chk("rst_adr", 32'(wishbone_adr), 0);
        chk("rst_datw", wishbone_dat_w, 0);
        chk("rst_sel", 32'(wishbone_sel), 0);
        chk("rst_cti", 32'(wishbone_cti), 0);
        chk("rst_bte", 32'(wishbone_bte), 0);
        reset_n = 1'b1;
        repeat (4) @(posedge clk48);
        #1;
        chk("post_rst_miso", 32'(spi_miso), 1);

        // Single write
        base = log_n;
        cs_assert();
        send_hdr(8'h01, 8'h00, 32'h00001000);
        send_word(32'hDEADBEEF);
        wait_nonff(6, b);
        cs_release();
        chk("wr1_status", 32'(b), 32'h00);
        chk("wr1_count", 32'(log_n - base), 1);
        chk("wr1_adr", log_adr[base % 64], 32'h400);
        chk("wr1_cti", 32'(log_cti[base % 64]), 3'b111);
        chk("wr1_sel", 32'(log_sel[base % 64]), 4'hF);
        chk("wr1_dat", log_dat[base % 64], 32'hDEADBEEF);
        chk("wr1_we", 32'(log_we[base % 64]), 1);

        // Four-word read burst
        base = log_n;
        cs_assert();
        send_hdr(8'h02, 8'h03, 32'h00000020);
        wait_nonff(8, b);
        chk("rd4_sync", 32'(b), 32'h00);
        for (int k = 0; k < 4; k++) begin
            recv_word(w);
            chk($sformatf("rd4_word%0d", k), w, 32'h11111111 * (k + 1));
        end
        spi_byte(8'h00, b);
        chk("rd4_tail", 32'(b), 32'hFF);
        cs_release();
        chk("rd4_count", 32'(log_n - base), 4);
        for (int k = 0; k < 4; k++) begin
            chk($sformatf("rd4_adr%0d", k), log_adr[(base + k) % 64], 32'h8 + k);
            chk($sformatf("rd4_cti%0d", k), 32'(log_cti[(base + k) % 64]), (k == 3) ? 3'b111 : 3'b010);
            chk($sformatf("rd4_we%0d", k), 32'(log_we[(base + k) % 64]), 0);
        end

        // Write burst clamped to FIFO depth
        base = log_n;
        cs_assert();
        send_hdr(8'h01, 8'd40, 32'h00000100);
        for (int k = 0; k < 16; k++) send_word(32'hA5000000 + k);
        wait_nonff(8, b);
        cs_release();
        chk("wr16_status", 32'(b), 32'h00);
        chk("wr16_count", 32'(log_n - base), 16);
        chk("wr16_adr0", log_adr[base % 64], 32'h40);
        chk("wr16_cti0", 32'(log_cti[base % 64]), 3'b010);
        chk("wr16_adr15", log_adr[(base + 15) % 64], 32'h4F);
        chk("wr16_cti15", 32'(log_cti[(base + 15) % 64]), 3'b111);
        chk("wr16_dat7", log_dat[(base + 7) % 64], 32'hA5000007);
        chk("wr16_dat15", log_dat[(base + 15) % 64], 32'hA500000F);

        // Error on the second word of a read
        err_at = 1;
        base = log_n;
        r0 = stb_rises;
        cs_assert();
        send_hdr(8'h02, 8'h03, 32'h00000040);
        wait_nonff(8, b);
        chk("rderr_sync", 32'(b), 32'hEE);
        spi_byte(8'h00, b);
        chk("rderr_tail", 32'(b), 32'hFF);
        cs_release();
        err_at = -1;
        chk("rderr_stbs", 32'(stb_rises - r0), 2);
        chk("rderr_count", 32'(log_n - base), 2);
        chk("rderr_cyc", 32'(wishbone_cyc), 0);

        // CS rise after the first word of a four-word write
        base = log_n;
        cs_assert();
        send_hdr(8'h01, 8'h03, 32'h00000200);
        send_word(32'h12345678);
        cs_release();
        chk("wrabort_count", 32'(log_n - base), 1);
        chk("wrabort_dat", log_dat[base % 64], 32'h12345678);
        chk("wrabort_cti", 32'(log_cti[base % 64]), 3'b010);
        chk("wrabort_cyc", 32'(wishbone_cyc), 0);
        base = log_n;
        cs_assert();
        send_hdr(8'h02, 8'h00, 32'h00000300);
        wait_nonff(8, b);
        chk("rd1_sync", 32'(b), 32'h00);
        recv_word(w);
        chk("rd1_word", w, 32'h11111111);
        spi_byte(8'h00, b);
        chk("rd1_tail", 32'(b), 32'hFF);
        cs_release();
        chk("rd1_adr", log_adr[base % 64], 32'hC0);
        chk("rd1_cti", 32'(log_cti[base % 64]), 3'b111);

        // Unknown opcode
        base = log_n;
        cs_assert();
        spi_byte(8'h55, b);
        for (int k = 0; k < 3; k++) begin
            spi_byte(8'h00, b);
            chk($sformatf("badop_miso%0d", k), 32'(b), 32'hFF);
        end
        cs_release();
        chk("badop_count", 32'(log_n - base), 0);

`ifdef SPIBONE_WB_TIMEOUT_EN
        // Slave never answers: watchdog ends the burst
        noack = 1'b1;
        h0 = stb_hi;
        cs_assert();
        send_hdr(8'h01, 8'h00, 32'h00000000);
        send_word(32'hCAFEF00D);
        wait_nonff(6, b);
        cs_release();
        noack = 1'b0;
        chk("to_status", 32'(b), 32'hEE);
        chk("to_stb_cycles", 32'(stb_hi - h0), 64);
        chk("to_cyc", 32'(wishbone_cyc), 0);
`else
        h0 = 0;
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/spibone_burst_bridge.md
# spibone_burst_bridge

SPI-slave to Wishbone-master bridge with parametrised data/address width and multi-word incrementing bursts, buffered through an internal word FIFO. It runs entirely in the `clk48` domain with the SPI pins synchronised in. It sits between the external SPI debug port and the SoC Wishbone crossbar. It supersedes the single-word SPI bridge in the `dut` wrapper.

## Interface
- `DATA_W`, 32: Wishbone data width. Must be 8, 16 or 32. `BPW = DATA_W/8` bytes per word.
- `ADDR_W`, 30: Wishbone word-address width, ≤30.
- `FIFO_DEPTH`, 16: burst buffer depth in words. Power of two, 2..256.
- `TIMEOUT_CYCLES`, 1024: bus watchdog limit. Used only with `SPIBONE_WB_TIMEOUT_EN`.

Ports:
- `clk48` in 1: system clock. Must be ≥4× `spi_clk`.
- `reset_n` in 1: asynchronous active-low reset.
- `spi_clk`, `spi_cs_n`, `spi_mosi` in 1: SPI mode 0, MSB first, asynchronous to `clk48`.
- `spi_miso` out 1: SPI data out.
- `wishbone_adr` out `ADDR_W`: word address.
- `wishbone_dat_w` out `DATA_W`: write data.
- `wishbone_dat_r` in `DATA_W`: read data.
- `wishbone_sel` out `DATA_W/8`: byte enables, all ones when `stb` is high.
- `wishbone_cyc`, `wishbone_stb`, `wishbone_we` out 1: bus cycle, strobe, write enable.
- `wishbone_cti` out 3: cycle type identifier.
- `wishbone_bte` out 2: burst type, always 2'b00.
- `wishbone_ack`, `wishbone_err` in 1: cycle termination.

## Operation
- **Synchronisers:** `spi_clk`, `spi_cs_n` and `spi_mosi` pass through 2-FF synchronisers. An edge detector runs on the synchronised clock.
  - MOSI is sampled on the rising edge.
  - MISO is updated on the falling edge.
  - The first MISO bit is presented when CS falls.
- **Frame format:**
  - `OP`: 0x01 = write, 0x02 = read.
  - `LEN`: word count minus 1. `n = min(LEN+1, FIFO_DEPTH)`.
  - `A3..A0`: big-endian byte address. `wishbone_adr = A[ADDR_W+1:2]`.
  - Payload follows the address.
- **Write payload:** `n` words of `BPW` bytes, big-endian.
  - Each completed word is pushed into the FIFO.
  - The bus side drains the FIFO concurrently with SPI reception.
  - After the last data byte, MISO returns status bytes: 0xFF while busy, 0x00 when done, 0xEE on error. The last status value repeats until CS rises.
- **Read payload:** the host clocks dummy bytes.
  - MISO returns 0xFF while the bus burst fills the FIFO.
  - After all `n` words are buffered (or on error), MISO returns one sync byte: 0x00 for OK, 0xEE for error.
  - On OK, `n` words follow, popped big-endian. After that, MISO returns 0xFF.
  - On error, MISO returns no data.
- **Unknown opcode:** the frame is ignored and MISO returns 0xFF until CS rises.
- **SPI FSM states:** IDLE → OPCODE → LEN → ADDR → (WDATA → STATUS) | (RWAIT → RDATA). CS rise in any state returns to IDLE.
- **Bus FSM states:** BIDLE → BREQ → BDONE.
  - `cyc` is held for the whole burst. `stb` is asserted per word.
  - `wishbone_cti` is 3'b010 for every word except the last, which uses 3'b111.
  - `wishbone_adr` increments by 1 per acked word and wraps at `2^ADDR_W`.
  - In write mode, `stb` is asserted only when the FIFO is non-empty. `cyc` stays high while waiting for data.
- **`wishbone_err`:** aborts the burst. `cyc` and `stb` drop the next cycle, the error flag is set, remaining words are not issued, and the FIFO is flushed.
- **CS rise mid-burst:** the current bus word completes normally through ack or err. `cyc` then drops, the FIFO is flushed and the remaining words are discarded.
- **Reset values:**
  - `spi_miso` = 1.
  - `cyc`, `stb`, `we`, `adr`, `dat_w`, `sel`, `cti`, `bte` = 0.
  - FIFO empty, both FSMs idle.

## Timing
- SPI input to internal edge detect latency: 3 `clk48` cycles.
- Write: FIFO push occurs 1 cycle after the last bit of each word. `stb` rises 1 cycle after the FIFO becomes non-empty.
- Read: the bus burst starts 1 cycle after the last address bit. The sync byte switches from 0xFF to 0x00 at the next byte boundary after the `n`-th ack.
- `stb` deasserts in the cycle after ack/err. It reasserts 1 cycle later for the next word, giving classic single-cycle gaps.
- FIFO full plus push: cannot occur because of the `n ≤ FIFO_DEPTH` clamp. Simultaneous push and pop is supported in the same cycle.
- A back-to-back frame with CS high for ≥4 `clk48` cycles must be accepted.

## Configuration
- `SPIBONE_WB_TIMEOUT_EN` defined: a counter starts at `stb` assertion. If no ack/err arrives within `TIMEOUT_CYCLES` cycles, the bridge treats it as an err: it drops `cyc`/`stb`, reports status 0xEE and flushes the FIFO.
- `SPIBONE_WB_TIMEOUT_EN` undefined: no counter exists and the bridge waits indefinitely for ack/err.

## Test plan
- Single write of 0xDEADBEEF to A=0x00001000, LEN=0 → one cycle with adr=0x400, cti=111, sel=F, dat_w=0xDEADBEEF. Status reads 0x00.
- Read burst at A=0x20, LEN=3, slave returns 0x11111111..0x44444444 → adr 0x8..0xB, cti 010,010,010,111. MISO sends 0xFF…, then 0x00, then 16 data bytes in order.
- Write burst with LEN=40 and FIFO_DEPTH=16 → exactly 16 bus writes. Status reads 0x00.
- Slave asserts err on the 2nd word of a 4-word read → `cyc` drops, no 3rd `stb`, sync byte 0xEE, MISO then 0xFF.
- CS rises after the 1st word of a 4-word write → the in-flight word acks, `cyc` drops, and the next frame (read LEN=0) works correctly.
- With `SPIBONE_WB_TIMEOUT_EN` and `TIMEOUT_CYCLES`=64, slave never acks → `cyc` drops 64 cycles after `stb`. Status reads 0xEE.
